rightshift_iter: RTL



---
 rtl/rightshift_iter_pkg.sv | 17 +
 rtl/rightshift_iter_stage.sv | 34 +++
 rtl/rightshift_iter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rightshift_iter_pkg.sv
// Shared definitions for the iterative right shifter: state encoding,
// fill-select constants and default widths.
package rightshift_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic SHIFT_SRL = 1'b0;
  localparam logic SHIFT_SRA = 1'b1;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_SHAMT_W = 5;

endpackage

// File: rtl/rightshift_iter_stage.sv
// One binary-weighted right-shift stage (shift by AMOUNT when i_ctrl is set).
// Optional macro RSHIFT_STICKY_EN adds the OR of the bits dropped off the LSB end.
module rightshift_iter_stage
  import rightshift_iter_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int AMOUNT = 1
) (
  input  logic [WIDTH-1:0] i_unshifted,
  input  logic             i_ctrl,
  input  logic             i_arith,
  output logic [WIDTH-1:0] o_data_result
`ifdef RSHIFT_STICKY_EN
  ,
  output logic             o_dropped
`endif
);

  localparam logic [WIDTH-1:0] FILL_MASK = ~({WIDTH{1'b1}} >> AMOUNT);

  logic w_fill;

  assign w_fill = (i_arith == SHIFT_SRA) & i_unshifted[WIDTH-1];

  assign o_data_result = i_ctrl ? ((i_unshifted >> AMOUNT) | (w_fill ? FILL_MASK : '0))
                                : i_unshifted;

`ifdef RSHIFT_STICKY_EN
  localparam logic [WIDTH-1:0] DROP_MASK = ~({WIDTH{1'b1}} << AMOUNT);

  assign o_dropped = i_ctrl & (|(i_unshifted & DROP_MASK));
`endif

endmodule

// File: rtl/rightshift_iter.sv
// Multi-cycle SRL/SRA right shifter, one binary-weighted stage per cycle.
// Optional macro RSHIFT_STICKY_EN adds the registered sticky output.
//
//   state    | meaning
//   ST_IDLE  | ready; accept start and latch operands
//   ST_SHIFT | apply stage 2**count, count down to 0
//   ST_DONE  | one-cycle done pulse, result registered
module rightshift_iter
  import rightshift_iter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_result
`ifdef RSHIFT_STICKY_EN
  ,
  output logic               sticky
`endif
);

  localparam int CNT_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_shamt;
  logic               r_arith;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_result;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_stage_data [SHAMT_W];
  logic [WIDTH-1:0]   w_sel_data;

`ifdef RSHIFT_STICKY_EN
  logic [SHAMT_W-1:0] w_stage_drop;
  logic               w_sel_drop;
  logic               r_sticky_acc;
  logic               r_sticky;
`endif

  assign w_last = (r_count == '0);

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
    rightshift_iter_stage #(
      .WIDTH (WIDTH),
      .AMOUNT(1 << g)
    ) u_stage (
      .i_unshifted  (r_work),
      .i_ctrl       (r_shamt[g]),
      .i_arith      (r_arith),
      .o_data_result(w_stage_data[g])
`ifdef RSHIFT_STICKY_EN
      ,
      .o_dropped    (w_stage_drop[g])
`endif
    );
  end

  // Only the stage addressed by the down-counter advances the working value.
  always_comb begin
    w_sel_data = r_work;
`ifdef RSHIFT_STICKY_EN
    w_sel_drop = 1'b0;
`endif
    for (int i = 0; i < SHAMT_W; i++) begin
      if (r_count == CNT_W'(i)) begin
        w_sel_data = w_stage_data[i];
`ifdef RSHIFT_STICKY_EN
        w_sel_drop = w_stage_drop[i];
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_work   <= '0;
      r_shamt  <= '0;
      r_arith  <= SHIFT_SRL;
      r_count  <= '0;
      r_result <= '0;
`ifdef RSHIFT_STICKY_EN
      r_sticky_acc <= 1'b0;
      r_sticky     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_work  <= data_operand;
      r_shamt <= shamt;
      r_arith <= arith;
      r_count <= CNT_W'(SHAMT_W - 1);
`ifdef RSHIFT_STICKY_EN
      r_sticky_acc <= 1'b0;
`endif
    end else if (busy) begin
      r_work <= w_sel_data;
`ifdef RSHIFT_STICKY_EN
      r_sticky_acc <= r_sticky_acc | w_sel_drop;
`endif
      if (w_last) begin
        r_result <= w_sel_data;
`ifdef RSHIFT_STICKY_EN
        r_sticky <= r_sticky_acc | w_sel_drop;
`endif
      end else begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign data_result = r_result;
`ifdef RSHIFT_STICKY_EN
  assign sticky = r_sticky;
`endif

endmodule
